toy_lsu_port_sched: RTL
=======================

Name: toy_lsu_port_sched

Overview:
Schedules three AGU request streams (load pipe, store pipe, replay queue) onto the single LSU cache request port. Fixed priority 0>1>2, with per-source starvation counters that promote a long-waiting source to urgent. Output is a registered slice, so the cache sees registered vld/pld. Sits between the AGU/replay logic and the dcache request interface, and replaces the purely combinational priority selection.

Parameters:
N_SRC, 3, number of requesters (fixed at 3 for this revision; payload array indices [2:0])
STARVE_THR, 8, consecutive wait cycles after which a valid source becomes urgent; 0 disables urgency (pure fixed priority)
WAIT_W, $clog2(STARVE_THR+1), width of each wait counter (derived, not overridden)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
v_s_vld  input  [2:0]  per-source request valid
v_s_rdy  output  [2:0]  per-source accept; handshake when vld&rdy
v_s_pld  input  agu_pkg [2:0]  per-source request payload
flush  input  1  pipeline flush: drop the held output request and clear wait counters
m_vld  output  1  registered request valid to cache
m_pld  output  agu_pkg  registered request payload to cache
m_rdy  input  1  cache accepts m_pld when m_vld&m_rdy
urgent  output  [2:0]  per-source urgent flag (debug/perf)

Behaviour:
- Reset (async, rst_n=0): m_vld=0, m_pld='0, all wait counters=0, urgent=0.
- Slot load condition: load_ok = ~flush & (~m_vld | m_rdy). This gives full throughput of 1 request per cycle with back-to-back m_rdy.
- Grant, combinational, one-hot: if any source has v_s_vld[i]&urgent[i], grant the lowest such index; else grant the lowest index with v_s_vld[i]; else no grant.
- v_s_rdy[i] = grant[i] & load_ok. At most one bit is set. v_s_rdy does not depend on v_s_vld[i] of the granted source beyond the grant itself.
- On a handshake (v_s_vld[i]&v_s_rdy[i]): m_pld<=v_s_pld[i] and m_vld<=1 at the next edge. Latency from accept to m_vld is 1 cycle.
- If m_vld&m_rdy and there is no new accept: m_vld<=0 and m_pld holds its value.
- If m_vld&~m_rdy: m_vld and m_pld hold stable until accepted. No source gets rdy.
- Sources must hold vld/pld stable until their handshake. The block does not check this.
- Wait counter i, per cycle:
  - clears to 0 if ~v_s_vld[i], or on a handshake of i, or on flush;
  - otherwise increments, saturating at STARVE_THR.
- urgent[i] = (STARVE_THR!=0) & (cnt[i]==STARVE_THR). It is registered-derived, so urgency affects the grant one cycle after the threshold is reached.
- Wait counters increment during output back-pressure (m_rdy low). Several sources can therefore become urgent together; urgent ones are then served in index order.
- Flush: at the next edge m_vld<=0 and counters<=0. During the flush cycle v_s_rdy=0, so no accept occurs. Flush wins over a simultaneous m_rdy or load. A held request dropped by flush is not presented again.
- Reset asserted mid-transfer: the held request is discarded immediately (async).

Decomposition:
- Package toy_pack: agu_pkg already exists there. Add LSU_ARB_N=3 and LSU_STARVE_THR_DEF=8.
- Sub-module toy_lsu_starve_cnt: one saturating wait counter plus urgent flag, instantiated N_SRC times. Inputs are clk, rst_n, vld, hs, flush; output is urgent.
- Grant logic, output slice and rdy generation stay in the top module.

Test Plan:
- Single source: src1 issues pld A at cycle 0 with m_rdy=1 -> v_s_rdy=3'b010 at cycle 0; m_vld=1, m_pld=A at cycle 1; m_vld=0 at cycle 2.
- All three valid, m_rdy=1, STARVE_THR=0 -> src0 is accepted every cycle; v_s_rdy[2:1]=0 throughout; m_vld stays high continuously.
- Starvation with STARVE_THR=4: src0 and src2 continuously valid, m_rdy=1 -> src0 accepted at cycles 0-3, urgent[2]=1 and src2 accepted at cycle 4, src0 resumes at cycle 5.
- Back-pressure: m_vld=1 with payload B and m_rdy=0 for 6 cycles -> m_pld stays B, v_s_rdy=0; with STARVE_THR=4, urgent[1] and urgent[2] both rise; on release src1 is granted before src2.
- Flush: m_vld=1, m_rdy=0, wait counters at 3, flush pulsed together with m_rdy=1 -> v_s_rdy=0 that cycle; next cycle m_vld=0 and all counters=0.
- Async reset: assert rst_n=0 mid-cycle while m_vld=1 -> m_vld=0 and urgent=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/toy_lsu_port_sched_pkg.sv
// Shared types and defaults for the LSU request-port scheduler.
// agu_pkg is the AGU request payload carried from AGU/replay into the dcache port.
package toy_pack;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        is_store;
        logic [4:0]  tag;
    } agu_pkg;

    localparam int LSU_ARB_N          = 3;
    localparam int LSU_STARVE_THR_DEF = 8;

    // Wait-counter width; a threshold of 0 still needs a 1-bit counter.
    function automatic int lsu_wait_w(input int thr);
        return (thr < 1) ? 1 : $clog2(thr + 1);
    endfunction

endpackage

// File: rtl/toy_lsu_starve_cnt.sv
// One per-source wait counter: counts consecutive unserved valid cycles,
// saturates at STARVE_THR, and flags the source urgent once it gets there.
module toy_lsu_starve_cnt
    import toy_pack::*;
#(
    parameter int STARVE_THR = LSU_STARVE_THR_DEF,
    parameter int WAIT_W     = lsu_wait_w(LSU_STARVE_THR_DEF)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld,
    input  logic hs,
    input  logic flush,
    output logic urgent
);

    localparam logic [WAIT_W-1:0] THR = WAIT_W'(STARVE_THR);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: assign the default before any branch so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (!vld || hs || flush) begin
            cnt_d = '0;
        end else if (cnt_q != THR) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            cnt_q <= cnt_d;
        end
    end

    assign urgent = (STARVE_THR != 0) && (cnt_q == THR);

endmodule

// File: rtl/toy_lsu_port_sched.sv
// Schedules load, store and replay AGU streams onto the single dcache request
// port: fixed priority 0>1>2 with starvation promotion, registered output slice.
module toy_lsu_port_sched
    import toy_pack::*;
#(
    parameter int N_SRC      = LSU_ARB_N,
    parameter int STARVE_THR = LSU_STARVE_THR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic   [N_SRC-1:0]   v_s_vld,
    output logic   [N_SRC-1:0]   v_s_rdy,
    input  agu_pkg [N_SRC-1:0]   v_s_pld,
    input  logic                 flush,
    output logic                 m_vld,
    output agu_pkg               m_pld,
    input  logic                 m_rdy,
    output logic   [N_SRC-1:0]   urgent
);

    localparam int WAIT_W = lsu_wait_w(STARVE_THR);

    logic             load_ok;
    logic [N_SRC-1:0] urg_req;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] grant;
    logic [N_SRC-1:0] hs;

    logic   m_vld_q, m_vld_d;
    agu_pkg m_pld_q, m_pld_d;

    // The slot can take a new request when empty or being drained this cycle.
    assign load_ok = !flush && (!m_vld_q || m_rdy);

    // Urgent requesters pre-empt the plain ones; lowest index wins within a class.
    assign urg_req = v_s_vld & urgent;
    assign cand    = (|urg_req) ? urg_req : v_s_vld;
    assign grant   = cand & (~cand + 1'b1);

    assign v_s_rdy = grant & {N_SRC{load_ok}};
    assign hs      = v_s_vld & v_s_rdy;

    for (genvar i = 0; i < N_SRC; i++) begin : g_cnt
        toy_lsu_starve_cnt #(
            .STARVE_THR (STARVE_THR),
            .WAIT_W     (WAIT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .vld    (v_s_vld[i]),
            .hs     (hs[i]),
            .flush  (flush),
            .urgent (urgent[i])
        );
    end

    always_comb begin
        m_vld_d = m_vld_q;
        m_pld_d = m_pld_q;
        if (flush) begin
            m_vld_d = 1'b0;
        end else if (|hs) begin
            m_vld_d = 1'b1;
            for (int i = 0; i < N_SRC; i++) begin
                if (hs[i]) begin
                    m_pld_d = v_s_pld[i];
                end
            end
        end else if (m_rdy) begin
            m_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld_q <= 1'b0;
            // NOTE: the payload is a single slice register, not a memory, so it is reset to a defined value.
            m_pld_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            m_pld_q <= m_pld_d;
        end
    end

    assign m_vld = m_vld_q;
    assign m_pld = m_pld_q;

endmodule
